key_event_controller: RTL

Sequences the 4x4 keypad scan results into a stream of discrete key events for the game/menu logic. Consumes the 16-bit pressed-key level vector from the keypad scanner, debounces it, and detects new presses. Serialises simultaneous presses in priority order and generates auto-repeat for a single held key. Delivers 4-bit key codes through a small FIFO with a valid/ready handshake.

---
 rtl/key_pkg.sv | 33 +++
 rtl/key_fifo.sv | 57 +++++
 rtl/key_event_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad event path: code widths, repeat FSM
// state encodings and small bit-vector helpers.
package key_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int KEY_NUM    = 16;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_PERIOD = 2'd2
    } rep_state_t;

    // Code of the lowest-index set bit; 0 when the vector is empty.
    function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [KEY_NUM-1:0] vec);
        logic [KEY_CODE_W-1:0] code;
        code = {KEY_CODE_W{1'b0}};
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                code = KEY_CODE_W'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    // True when exactly one key is down.
    function automatic logic is_single(input logic [KEY_NUM-1:0] vec);
        return (vec != 16'd0) && ((vec & (vec - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always visible on dout;
// a push into a full FIFO is accepted only when a pop happens the same cycle.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full    = (count_r == (AW + 1)'(DEPTH));
    assign empty   = (count_r == {(AW + 1){1'b0}});
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);
    assign dout    = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/key_event_controller.sv
// Turns the raw keypad level vector into discrete key events: debounce,
// new-press detection, priority serialisation, single-key auto-repeat and
// a small event FIFO toward the consumer.
module key_event_controller
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ready,
    output logic [15:0] held,
    output logic        overflow
);

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);

    logic [KEY_NUM-1:0]    candidate_r;
    logic [DCW-1:0]        cnt_r;
    logic [KEY_NUM-1:0]    pending_r;
    logic [KEY_NUM-1:0]    pending_next_s;
    logic [KEY_NUM-1:0]    pend_clr_s;
    rep_state_t            state_r;
    rep_state_t            state_next_s;
    logic [RCW-1:0]        rcnt_r;
    logic [RCW-1:0]        rcnt_next_s;
    logic [KEY_CODE_W-1:0] rkey_r;
    logic [KEY_CODE_W-1:0] rkey_next_s;
    logic                  rreq_r;
    logic                  rreq_next_s;
    logic                  held_upd_s;
    logic                  pend_any_s;
    logic                  svc_s;
    logic                  can_push_s;
    logic                  push_s;
    logic                  pop_s;
    logic [KEY_CODE_W-1:0] push_code_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    // held changes only on the cycle a stable candidate differs from it.
    assign held_upd_s = (keys == candidate_r) &&
                        (cnt_r == DCW'(DEBOUNCE_CYCLES - 1)) &&
                        (candidate_r != held);
    assign key_valid  = !fifo_empty_s;
    assign pop_s      = key_valid && key_ready;
    assign can_push_s = !fifo_full_s || pop_s;
    assign pend_any_s = (pending_r != 16'd0);
    // A repeat is only considered on a cycle with no press waiting.
    assign svc_s      = rreq_r && !pend_any_s;

    // Single shared debounce counter for the whole vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            candidate_r <= 16'd0;
            cnt_r       <= {DCW{1'b0}};
            held        <= 16'd0;
        end else if (keys != candidate_r) begin
            candidate_r <= keys;
            cnt_r       <= {DCW{1'b0}};
        end else if (cnt_r == DCW'(DEBOUNCE_CYCLES - 1)) begin
            held <= candidate_r;
        end else begin
            cnt_r <= cnt_r + DCW'(1);
        end
    end

    // Push selection: pending presses first, then a waiting repeat.
    always_comb begin
        push_s      = 1'b0;
        push_code_s = rkey_r;
        pend_clr_s  = 16'd0;
        if (pend_any_s) begin
            push_code_s = lowest_set(pending_r);
            push_s      = can_push_s;
            if (can_push_s) begin
                pend_clr_s = 16'd1 << push_code_s;
            end else begin
                pend_clr_s = 16'd0;
            end
        end else begin
            push_s = svc_s && can_push_s;
        end
        pending_next_s = (pending_r & ~pend_clr_s) |
                         (held_upd_s ? (candidate_r & ~held) : 16'd0);
    end

    // Repeat FSM next state; any held update re-evaluates the single-key condition.
    always_comb begin
        state_next_s = state_r;
        rcnt_next_s  = rcnt_r;
        rkey_next_s  = rkey_r;
        rreq_next_s  = rreq_r && !svc_s;
        if (held_upd_s) begin
            rreq_next_s = 1'b0;
            rcnt_next_s = {RCW{1'b0}};
            if (is_single(candidate_r)) begin
                state_next_s = R_DELAY;
                rkey_next_s  = lowest_set(candidate_r);
            end else begin
                state_next_s = R_IDLE;
            end
        end else begin
            case (state_r)
                R_IDLE: begin
                    rcnt_next_s = {RCW{1'b0}};
                end
                R_DELAY: begin
                    if (rcnt_r == RCW'(REPEAT_DELAY - 1)) begin
                        rreq_next_s  = 1'b1;
                        state_next_s = R_PERIOD;
                        rcnt_next_s  = {RCW{1'b0}};
                    end else begin
                        rcnt_next_s = rcnt_r + RCW'(1);
                    end
                end
                R_PERIOD: begin
                    if (rcnt_r == RCW'(REPEAT_PERIOD - 1)) begin
                        rreq_next_s = 1'b1;
                        rcnt_next_s = {RCW{1'b0}};
                    end else begin
                        rcnt_next_s = rcnt_r + RCW'(1);
                    end
                end
                default: begin
                    state_next_s = R_IDLE;
                    rcnt_next_s  = {RCW{1'b0}};
                    rreq_next_s  = 1'b0;
                end
            endcase
        end
    end

    // Pending bitmap, repeat FSM registers and the overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 16'd0;
            state_r   <= R_IDLE;
            rcnt_r    <= {RCW{1'b0}};
            rkey_r    <= {KEY_CODE_W{1'b0}};
            rreq_r    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            state_r   <= state_next_s;
            rcnt_r    <= rcnt_next_s;
            rkey_r    <= rkey_next_s;
            rreq_r    <= rreq_next_s;
            overflow  <= svc_s && !can_push_s;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (push_code_s),
        .pop   (pop_s),
        .dout  (key_code),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

endmodule
